// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART link controller.
//   tx_state_e  - transmit-side FSM states
//   rx_state_e  - receive-side FSM states
//   BYTE_W      - byte width carried on both paths
//   DEF_START_TIMEOUT - default cycles to wait for tx_busy after tx_start
package uart_pkg;

  localparam int BYTE_W            = 8;
  localparam int DEF_START_TIMEOUT = 1023;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE     = 2'd0,
    RX_CLR      = 2'd1,
    RX_WAIT_LOW = 2'd2
  } rx_state_e;

endpackage

// File: rtl/uart_link_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req   [NREQ-1:0] - request vector
//   ptr   [IW-1:0]   - index of the last granted requester
//   grant [NREQ-1:0] - one-hot grant, zero when no request is set
// Search order is ptr+1, ptr+2, ... wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  // Walk from the farthest candidate to the nearest so the nearest
  // requesting index overwrites any earlier pick.
  always_comb begin
    grant = '0;
    for (int k = NREQ; k >= 1; k--) begin
      for (int j = 0; j < NREQ; j++) begin
        if ((j == ((int'(ptr) + k) % NREQ)) && req[j]) begin
          grant    = '0;
          grant[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_link_ctrl.sv
// uart_link_ctrl: arbitrates NREQ byte requesters onto one UART transmitter
// and buffers bytes from the UART receiver into a valid/ready stream.
//   clk, rst            - clock, synchronous active-low reset
//   req_valid/req_data  - per-requester pending byte (byte i on [8i+7:8i])
//   req_ready           - one-cycle accept pulse to the winning requester
//   tx_start/tx_data    - start strobe and byte to the transmitter
//   tx_busy             - transmitter busy
//   uart_rdy/uart_data  - receiver byte-ready flag and byte
//   uart_rdy_clr        - one-cycle clear pulse to the receiver
//   rx_valid/rx_data    - received byte stream, rx_ready accepts
//   err_timeout/err_clr - sticky start-timeout flag and its clear
//   tx_grant_id         - index of the requester last accepted
//   tx_state/rx_state   - current FSM states for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. On the requester side req_ready is the accept pulse; on the rx
// side rx_valid stays asserted and rx_data stays stable until rx_ready.
module uart_link_ctrl
  import uart_pkg::*;
#(
  parameter int NREQ          = 4,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT,
  localparam int IW           = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [BYTE_W*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_start,
  output logic [BYTE_W-1:0]        tx_data,
  input  logic                     tx_busy,
  input  logic                     uart_rdy,
  input  logic [BYTE_W-1:0]        uart_data,
  output logic                     uart_rdy_clr,
  output logic                     rx_valid,
  output logic [BYTE_W-1:0]        rx_data,
  input  logic                     rx_ready,
  output logic                     err_timeout,
  input  logic                     err_clr,
  output logic [IW-1:0]            tx_grant_id,
  output logic [1:0]               tx_state,
  output logic [1:0]               rx_state
);

  localparam int TW = $clog2(START_TIMEOUT + 1);

  // ---------------- TX path ----------------
  tx_state_e         tx_st, tx_nx;
  logic [IW-1:0]     ptr;
  logic [TW-1:0]     timer;
  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     grant_idx;
  logic [BYTE_W-1:0] grant_byte;
  logic              do_grant;
  logic              timeout_hit;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    grant_idx  = '0;
    grant_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_idx  = IW'(i);
        grant_byte = req_data[BYTE_W*i +: BYTE_W];
      end
    end
  end

  // Gated by rst so no accept pulse escapes while reset is held.
  assign do_grant    = rst && (tx_st == ST_IDLE) && (|req_valid);
  assign timeout_hit = (tx_st == ST_START) && !tx_busy &&
                       (timer == TW'(START_TIMEOUT - 1));

  always_comb begin
    tx_nx = tx_st;
    case (tx_st)
      ST_IDLE:      if (|req_valid) tx_nx = ST_START;
      ST_START: begin
        if (tx_busy)          tx_nx = ST_WAIT_DONE;
        else if (timeout_hit) tx_nx = ST_IDLE;
      end
      ST_WAIT_DONE: if (!tx_busy) tx_nx = ST_IDLE;
      default:      tx_nx = ST_IDLE;
    endcase
  end

  assign req_ready = do_grant ? grant : '0;
  assign tx_start  = (tx_st == ST_START);
  assign tx_state  = tx_st;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_st       <= ST_IDLE;
      ptr         <= IW'(NREQ - 1);
      timer       <= '0;
      tx_data     <= '0;
      tx_grant_id <= '0;
      err_timeout <= 1'b0;
    end else begin
      tx_st <= tx_nx;
      if (do_grant) begin
        ptr         <= grant_idx;
        tx_grant_id <= grant_idx;
        tx_data     <= grant_byte;
        timer       <= '0;
      end else if (tx_st == ST_START) begin
        timer <= timer + 1'b1;
      end
      // A new timeout takes priority over a clear in the same cycle.
      if (timeout_hit)  err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

  // ---------------- RX path ----------------
  rx_state_e rx_st, rx_nx;
  logic      pop;
  logic      capture;

  assign pop     = rx_valid && rx_ready;
  assign capture = (rx_st == RX_IDLE) && uart_rdy && (!rx_valid || pop);

  // After clearing the receiver, wait for uart_rdy to be seen low so a
  // flag that lags the clear is not captured a second time.
  always_comb begin
    rx_nx = rx_st;
    case (rx_st)
      RX_IDLE:     if (capture) rx_nx = RX_CLR;
      RX_CLR:      rx_nx = RX_WAIT_LOW;
      RX_WAIT_LOW: if (!uart_rdy) rx_nx = RX_IDLE;
      default:     rx_nx = RX_IDLE;
    endcase
  end

  assign uart_rdy_clr = (rx_st == RX_CLR);
  assign rx_state     = rx_st;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_st    <= RX_IDLE;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_st <= rx_nx;
      if (capture) begin
        rx_valid <= 1'b1;
        rx_data  <= uart_data;
      end else if (pop) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_link_ctrl.sv
// tb_uart_link_ctrl: drives uart_link_ctrl with requesters, a behavioural
// UART (transmitter looped back into receiver) and a consumer. Requesters,
// UART and consumer all act once per cycle on the falling clock edge.
module tb_uart_link_ctrl;
  import uart_pkg::*;

  localparam int NREQ = 4;
  localparam int TO   = 1023;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy = 1'b0;
  logic              uart_rdy = 1'b0;
  logic [7:0]        uart_data = '0;
  logic              uart_rdy_clr;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready = 1'b0;
  logic              err_timeout;
  logic              err_clr = 1'b0;
  logic [1:0]        tx_grant_id;
  logic [1:0]        tx_state;
  logic [1:0]        rx_state;

  uart_link_ctrl #(.NREQ(NREQ), .START_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .uart_rdy(uart_rdy), .uart_data(uart_data),
    .uart_rdy_clr(uart_rdy_clr), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .err_timeout(err_timeout), .err_clr(err_clr),
    .tx_grant_id(tx_grant_id), .tx_state(tx_state), .rx_state(rx_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  int         grant_log[$];

  logic [7:0] rbuf [NREQ][16];
  int         rhead [NREQ];
  int         rtail [NREQ];
  bit         req_on [NREQ];
  int         wait_grants [NREQ];
  int         last_grant;
  bit         rand_gap = 1'b0;
  bit         drop_mode = 1'b0;

  bit         pend_valid = 1'b0;
  int         pend_id;
  logic [7:0] pend_byte;

  bit         phy_en = 1'b1;
  int         phy_mode = 0;
  int         phy_cnt = 0;
  logic [7:0] phy_byte;
  bit         clr_pend = 1'b0;
  int         clr_delay = 0;
  int         rdy_low_cnt = 2;
  bit         prev_clr = 1'b0;
  int         n_clr = 0;
  int         n_sent = 0;
  int         start_hi_cnt = 0;
  int         ready_pulses = 0;

  int         rx_mode = 2;
  bit         prev_rx_valid = 1'b0;
  logic [7:0] prev_rx_data;
  bit         prev_hs = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic add_byte(input int id, input logic [7:0] b);
    rbuf[id][rtail[id] % 16] = b;
    rtail[id]++;
  endtask

  // Behavioural UART: transmitter takes tx_start after a random delay,
  // stays busy a few cycles, then hands the byte to its receiver once the
  // receiver flag has been low long enough to be seen by the link.
  task automatic phy_step();
    if (uart_rdy_clr) begin
      check("rdy_clr_while_rdy", uart_rdy, 1);
      check("rdy_clr_single", prev_clr, 0);
      clr_pend  = 1'b1;
      clr_delay = $urandom_range(0, 2);
      n_clr++;
    end
    prev_clr = uart_rdy_clr;
    if (clr_pend) begin
      if (clr_delay == 0) begin
        uart_rdy = 1'b0;
        clr_pend = 1'b0;
      end else clr_delay--;
    end
    rdy_low_cnt = uart_rdy ? 0 : rdy_low_cnt + 1;
    if (tx_start) start_hi_cnt++;
    if (pend_valid) begin
      check("tx_start_after_grant", tx_start, 1);
      check("tx_data_granted", tx_data, pend_byte);
      check("tx_grant_id", tx_grant_id, pend_id);
      pend_valid = 1'b0;
    end
    if (phy_en) begin
      case (phy_mode)
        0: if (tx_start) begin
          phy_byte = tx_data;
          phy_cnt  = $urandom_range(0, 3);
          phy_mode = 1;
        end
        1: begin
          check("tx_start_held", tx_start, 1);
          check("tx_data_stable", tx_data, phy_byte);
          if (phy_cnt == 0) begin
            tx_busy  = 1'b1;
            phy_cnt  = $urandom_range(2, 8);
            phy_mode = 2;
          end else phy_cnt--;
        end
        default: begin
          check("tx_start_dropped", tx_start, 0);
          if (phy_cnt != 0) phy_cnt--;
          else if (rdy_low_cnt >= 2 && !clr_pend) begin
            tx_busy   = 1'b0;
            uart_rdy  = 1'b1;
            uart_data = phy_byte;
            phy_mode  = 0;
            n_sent++;
          end
        end
      endcase
    end
  endtask

  task automatic rx_step();
    bit hs;
    case (rx_mode)
      0:       rx_ready = ($urandom_range(0, 3) != 0);
      1:       rx_ready = 1'b0;
      default: rx_ready = 1'b1;
    endcase
    if (prev_rx_valid && !prev_hs) begin
      check("rx_valid_held", rx_valid, 1);
      check("rx_data_stable", rx_data, prev_rx_data);
    end
    hs = rx_valid && rx_ready;
    if (hs) begin
      check("rx_byte_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("rx_byte", rx_data, exp_q.pop_front());
    end
    prev_rx_valid = rx_valid;
    prev_rx_data  = rx_data;
    prev_hs       = hs;
  endtask

  task automatic req_step();
    int         exp_w;
    int         w;
    logic [31:0] m;
    logic [7:0] b;
    for (int i = 0; i < NREQ; i++) begin
      if (!req_on[i] && rhead[i] != rtail[i] && (!rand_gap || $urandom_range(0, 2) == 0))
        req_on[i] = 1'b1;
      req_valid[i]      = req_on[i];
      req_data[8*i +: 8] = req_on[i] ? rbuf[i][rhead[i] % 16] : 8'($urandom);
    end
    #1;
    check("req_ready_onehot", $countones(req_ready) <= 1, 1);
    if (req_ready != '0) begin
      exp_w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (last_grant + k) % NREQ;
        if (exp_w < 0 && req_on[j]) exp_w = j;
      end
      m = (exp_w >= 0) ? (32'd1 << exp_w) : 32'd0;
      check("rr_winner", req_ready, m);
      w = 0;
      for (int j = 0; j < NREQ; j++) if (req_ready[j]) w = j;
      check("wait_bound", wait_grants[w] <= NREQ - 1, 1);
      for (int j = 0; j < NREQ; j++) if (j != w && req_on[j]) wait_grants[j]++;
      wait_grants[w] = 0;
      b = rbuf[w][rhead[w] % 16];
      if (rhead[w] != rtail[w]) rhead[w]++;
      req_on[w]  = 1'b0;
      pend_valid = 1'b1;
      pend_id    = w;
      pend_byte  = b;
      last_grant = w;
      grant_log.push_back(w);
      ready_pulses++;
      if (!drop_mode) exp_q.push_back(b);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    phy_step();
    rx_step();
    req_step();
  endtask

  task automatic model_reset();
    phy_mode = 0; tx_busy = 1'b0; uart_rdy = 1'b0; clr_pend = 1'b0;
    rdy_low_cnt = 2; prev_clr = 1'b0; pend_valid = 1'b0;
    prev_rx_valid = 1'b0; prev_hs = 1'b0;
    exp_q.delete();
    last_grant = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      req_on[i] = 1'b0; rhead[i] = rtail[i]; wait_grants[i] = 0;
    end
    req_valid = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_uart_rdy_clr"}, uart_rdy_clr, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_err_timeout"}, err_timeout, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_rx_data"}, rx_data, 0);
    check({tag, "_tx_grant_id"}, tx_grant_id, 0);
    check({tag, "_tx_state"}, tx_state, ST_IDLE);
    check({tag, "_rx_state"}, rx_state, RX_IDLE);
  endtask

  task automatic apply_reset(input int n, input string tag);
    rst = 1'b0;
    model_reset();
    repeat (n) tick();
    check_reset_values(tag);
    rst = 1'b1;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < bound && !done; c++) begin
      tick();
      done = (exp_q.size() == 0) && phy_mode == 0 && !tx_busy && !uart_rdy &&
             !rx_valid && !clr_pend;
      for (int i = 0; i < NREQ; i++)
        if (req_on[i] || rhead[i] != rtail[i]) done = 1'b0;
    end
    check({tag, "_drained"}, done, 1);
  endtask

  task automatic run_timeout(input string tag);
    bool_loop: begin
      bit fell;
      fell = 1'b0;
      for (int c = 0; c < 3000 && !fell; c++) begin
        tick();
        if (start_hi_cnt > 0 && !tx_start) fell = 1'b1;
      end
      check({tag, "_ended"}, fell, 1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int clr0;
    int sent0;
    bit seen;
    for (int i = 0; i < NREQ; i++) begin
      rhead[i] = 0; rtail[i] = 0; req_on[i] = 1'b0; wait_grants[i] = 0;
    end
    last_grant = NREQ - 1;
    apply_reset(3, "reset");

    // Single byte: accept in the same cycle as valid, loop back to rx.
    rx_mode = 2;
    clr0 = n_clr;
    add_byte(0, 8'h13);
    tick();
    check("single_ready_same_cycle", req_ready, 4'b0001);
    wait_idle(500, "single");
    check("single_clr_count", n_clr - clr0, 1);

    // Fairness from reset: 0,1,2,3 then requester 0 again.
    apply_reset(1, "reset2");
    grant_log.delete();
    add_byte(0, 8'h50); add_byte(1, 8'h00); add_byte(2, 8'hA5); add_byte(3, 8'hFF);
    add_byte(0, 8'h77);
    wait_idle(1000, "fair");
    check("fair_grant_count", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check($sformatf("fair_order_%0d", i), grant_log[i], (i == 4) ? 0 : i);

    // Start timeout with the transmitter never going busy.
    phy_en = 1'b0; drop_mode = 1'b1;
    start_hi_cnt = 0; ready_pulses = 0;
    add_byte(2, 8'h5A);
    run_timeout("to1");
    check("to1_start_cycles", start_hi_cnt, TO);
    check("to1_err_set", err_timeout, 1);
    check("to1_ready_pulses", ready_pulses, 1);
    repeat (4) tick();
    check("to1_no_retry", start_hi_cnt, TO);
    check("to1_err_sticky", err_timeout, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to1_err_cleared", err_timeout, 0);

    // Timeout while err_clr is held: the set wins.
    start_hi_cnt = 0;
    err_clr = 1'b1;
    add_byte(1, 8'h66);
    run_timeout("to2");
    check("to2_set_wins", err_timeout, 1);
    err_clr = 1'b0;
    phy_en = 1'b1; drop_mode = 1'b0;

    // Reset while the transmitter is busy (link waiting for done).
    add_byte(2, 8'hC3);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      tick();
      if (phy_mode == 2) seen = 1'b1;
    end
    check("mid_reset_busy_seen", seen, 1);
    tick();
    rst = 1'b0;
    model_reset();
    tick();
    check_reset_values("mid_reset");
    rst = 1'b1;
    grant_log.delete();
    add_byte(3, 8'h3C);
    wait_idle(500, "after_reset");
    check("after_reset_grant", (grant_log.size() == 1) ? grant_log[0] : -1, 3);

    // RX backpressure: second clear withheld until the buffer frees.
    rx_mode = 1;
    clr0 = n_clr; sent0 = n_sent;
    add_byte(1, 8'h11); add_byte(1, 8'h22);
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      tick();
      if (n_sent - sent0 == 2) seen = 1'b1;
    end
    check("bp_both_sent", seen, 1);
    repeat (20) tick();
    check("bp_clr_withheld", n_clr - clr0, 1);
    check("bp_uart_rdy_held", uart_rdy, 1);
    check("bp_rx_valid", rx_valid, 1);
    check("bp_rx_first", rx_data, 8'h11);
    rx_mode = 2;
    wait_idle(500, "bp");
    check("bp_clr_total", n_clr - clr0, 2);

    // Randomized traffic with gaps and a stalling consumer.
    rx_mode = 0; rand_gap = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      int nb;
      nb = $urandom_range(3, 8);
      for (int k = 0; k < nb; k++) add_byte(i, 8'($urandom));
    end
    wait_idle(20000, "random");
    check("random_no_timeout", err_timeout, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_link_ctrl.md
UART_LINK_CTRL -- requirements
Module: uart_link_ctrl

Interface
REQ-001 Parameter NREQ, default 4: number of transmit requesters, range 2..8.
REQ-002 Parameter START_TIMEOUT, default 1023: maximum cycles in ST_START waiting for tx_busy before abort.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
REQ-005 req_valid  input  NREQ  per-requester byte-pending flag.
REQ-006 req_data  input  8*NREQ  byte for requester i on bits [8i+7:8i].
REQ-007 req_ready  output  NREQ  one-cycle accept pulse, at most one bit set.
REQ-008 tx_start  output  1  start strobe to the UART transmitter.
REQ-009 tx_data  output  8  byte to the UART transmitter.
REQ-010 tx_busy  input  1  transmitter busy flag.
REQ-011 uart_rdy  input  1  receiver byte-ready flag.
REQ-012 uart_data  input  8  receiver byte.
REQ-013 uart_rdy_clr  output  1  one-cycle clear pulse to the receiver.
REQ-014 rx_valid, rx_data[7:0]  output  received-byte stream; rx_ready  input  1  consumer accept.
REQ-015 err_timeout  output  1  sticky start-timeout flag; err_clr  input  1  clears it.
REQ-016 tx_grant_id  output  ceil(log2 NREQ)  index of the requester last accepted.

Function
REQ-017 TX FSM states: ST_IDLE, ST_START, ST_WAIT_DONE.
REQ-018 ST_IDLE: if any req_valid bit is set, grant round-robin starting at (last grant + 1) mod NREQ; in the same cycle, pulse req_ready for the winner, latch its byte into tx_data, and update tx_grant_id; go to ST_START.
REQ-019 Latency: req_valid high in ST_IDLE at cycle N -> req_ready at N and tx_start high from N+1.
REQ-020 ST_START: hold tx_start=1 and tx_data stable; when tx_busy=1, go to ST_WAIT_DONE with tx_start=0 from the next cycle.
REQ-021 ST_START timeout: after START_TIMEOUT cycles without tx_busy, drop tx_start, set err_timeout, discard the byte, and return to ST_IDLE.
REQ-022 ST_WAIT_DONE: on tx_busy=0, return to ST_IDLE; the next grant comes no earlier than the following cycle (minimum one idle cycle between bytes).
REQ-023 Round-robin pointer advances only on grant; a requester with req_valid held waits at most NREQ-1 grants.
REQ-024 req_valid changes while not in ST_IDLE are ignored; tx_data does not change outside ST_IDLE.
REQ-025 RX capture: when uart_rdy=1 and the RX buffer is empty (or is being emptied this cycle by rx_valid&rx_ready), latch uart_data into rx_data, set rx_valid, and pulse uart_rdy_clr for exactly one cycle.
REQ-026 After a uart_rdy_clr pulse, ignore uart_rdy until it has been observed low (RX states RX_IDLE, RX_CLR, RX_WAIT_LOW), so a stale flag does not cause a double capture.
REQ-027 If the RX buffer is full, uart_rdy_clr is withheld; the byte stays in the receiver until the buffer frees.
REQ-028 rx_valid stays set and rx_data stays stable until rx_valid&rx_ready.
REQ-029 err_clr and a new timeout in the same cycle: set wins.
REQ-030 TX and RX paths are independent; simultaneous activity has no interaction.

Reset
REQ-031 With rst=0: FSMs go to ST_IDLE/RX_IDLE, pointer=NREQ-1 (first grant favours requester 0), and tx_start, req_ready, uart_rdy_clr, rx_valid and err_timeout are all 0.
REQ-032 At reset: tx_data, rx_data and tx_grant_id = 0.
REQ-033 Reset mid-transfer aborts immediately; the in-flight byte is lost and tx_start is 0 in the next cycle.

Structure
REQ-034 Shared package uart_pkg holds the TX and RX state enums, the default START_TIMEOUT, and the byte width constant (8).
REQ-035 One sub-module, rr_arbiter (NREQ requests plus pointer in, one-hot grant out), is instantiated once.

Verification
REQ-036 Bench pairs the block with the UART top module (loopback) and a behavioural consumer.
REQ-037 Single byte: req_valid[0] with 0x13 -> req_ready[0] same cycle, tx_start next cycle held until busy, then rx_data=0x13 with one uart_rdy_clr pulse.
REQ-038 Fairness: all four requesters valid (0x50, 0x00, 0xA5, 0xFF) after reset -> grant order 0,1,2,3; rx stream in the same order; requester 0 re-armed is granted only after 3.
REQ-039 Timeout: tx_busy tied 0 -> tx_start high exactly 1023 cycles, err_timeout=1, req_ready pulsed once; err_clr -> err_timeout=0.
REQ-040 RX backpressure: rx_ready=0 across two received bytes -> the second uart_rdy_clr is withheld; rx_ready=1 -> bytes delivered in order with none lost.
REQ-041 Reset mid-ST_WAIT_DONE -> all outputs at reset values the next cycle; the next request is served normally.
